// File: rtl/ws2812_rx.sv
// WS2812 single-wire receive decoder: classifies high pulses by width into bits,
// assembles MSB-first 24-bit words and flags the end-of-frame reset gap.
module ws2812_rx #(
    parameter int THRESH    = 29,
    parameter int MIN_HIGH  = 6,
    parameter int MAX_HIGH  = 72,
    parameter int RESET_CYC = 2400,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [23:0]      data,
    output logic             valid,
    output logic [IDX_W-1:0] word_idx,
    output logic             latch,
    output logic             err
);
    localparam int CNT_TOP = (RESET_CYC > MAX_HIGH) ? RESET_CYC : MAX_HIGH;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_C   = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH} state_t;

    state_t           state, state_n;
    logic             s1, s2, prev;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [23:0]      shreg, shreg_n, data_n;
    logic [4:0]       bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0] next_idx, next_idx_n, word_idx_n;
    logic             valid_n, latch_n, err_n;
    logic             rise, fall, bit_val;

    assign rise    = s2 & ~prev;
    assign fall    = ~s2 & prev;
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
    assign bit_val = (cnt >= THRESH_C);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        next_idx_n = next_idx;
        data_n     = data;
        word_idx_n = word_idx;
        valid_n    = 1'b0;
        latch_n    = 1'b0;
        err_n      = 1'b0;
        case (state)
            WAIT_GAP: begin
                if (s2) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= RESET_C) state_n = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = HIGH;
                end else if (!s2) begin
                    cnt_n = cnt_inc;
                    // Coming out of WAIT_GAP cnt already sits at RESET_C, so no latch there.
                    if (cnt_inc == RESET_C && cnt_inc != cnt) begin
                        latch_n    = 1'b1;
                        err_n      = (bit_cnt != 5'd0);
                        next_idx_n = '0;
                        bit_cnt_n  = 5'd0;
                        shreg_n    = '0;
                    end
                end
            end
            HIGH: begin
                if (s2) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= MAX_C) begin
                        err_n     = 1'b1;
                        bit_cnt_n = 5'd0;
                        shreg_n   = '0;
                        cnt_n     = '0;
                        state_n   = WAIT_GAP;
                    end
                end else if (fall) begin
                    // The fall sample is already low, so the low count starts at one.
                    cnt_n = CNT_ONE;
                    if (cnt < MIN_C) begin
                        err_n     = 1'b1;
                        bit_cnt_n = 5'd0;
                        shreg_n   = '0;
                        state_n   = WAIT_GAP;
                    end else begin
                        shreg_n = {shreg[22:0], bit_val};
                        state_n = IDLE;
                        if (bit_cnt == 5'd23) begin
                            data_n     = {shreg[22:0], bit_val};
                            valid_n    = 1'b1;
                            word_idx_n = next_idx;
                            next_idx_n = next_idx + IDX_W'(1);
                            bit_cnt_n  = 5'd0;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end
                end
            end
            default: state_n = WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
            state    <= WAIT_GAP;
            cnt      <= '0;
            shreg    <= '0;
            bit_cnt  <= 5'd0;
            next_idx <= '0;
            data     <= '0;
            word_idx <= '0;
            valid    <= 1'b0;
            latch    <= 1'b0;
            err      <= 1'b0;
        end else begin
            s1       <= din;
            s2       <= s1;
            prev     <= s2;
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            next_idx <= next_idx_n;
            data     <= data_n;
            word_idx <= word_idx_n;
            valid    <= valid_n;
            latch    <= latch_n;
            err      <= err_n;
        end
    end
endmodule
